// File: rtl/inst_loader_ctrl.sv
// inst_loader_ctrl
//   Boot-time loader: receives a program image as a UART byte stream,
//   assembles little-endian 32-bit words and writes them to consecutive
//   instruction BRAM addresses starting at 0, then raises a sticky done.
//
//   Image format: 4-byte little-endian length N (in words), N payload words,
//   and, when LOADER_CHECKSUM_EN is defined, a 4-byte little-endian trailer
//   equal to the mod-2^32 sum of the payload words.
//
//   Optional feature macro: LOADER_CHECKSUM_EN (checksum trailer + CSUM state).
//
// Ports
//   clk          single clock
//   rstn         synchronous active-low reset
//   start        one-cycle pulse, begins a load (honoured in IDLE/DONE only)
//   rx_valid     one-cycle strobe, rx_data holds a byte
//   rx_data      received byte
//   bram_addr    registered BRAM word address
//   bram_din     registered BRAM write data
//   bram_we      registered one-cycle write pulse per word
//   busy         high in HDR, DATA, CSUM
//   done         sticky load complete
//   err          sticky error (oversize length / checksum mismatch)
//   words_loaded words written in the current or last load
module inst_loader_ctrl #(
  parameter int unsigned ADDR_W = 14
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [31:0]       bram_din,
  output logic              bram_we,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   words_loaded
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_DATA,
`ifdef LOADER_CHECKSUM_EN
    S_CSUM,
`endif
    S_DONE
  } state_t;

  // Largest legal length: the BRAM capacity in words.
  localparam logic [32:0]     CAP   = 33'(1) << ADDR_W;
  localparam logic [ADDR_W:0] W_ONE = (ADDR_W+1)'(1);

  state_t              state_q, state_d;
  logic [1:0]          lane_q, lane_d;
  logic [23:0]         shift_q, shift_d;   // the three previous bytes of the word
  logic [ADDR_W:0]     len_q, len_d;
  logic [ADDR_W-1:0]   addr_d;
  logic [31:0]         din_d;
  logic                we_d, done_d, err_d;
  logic [ADDR_W:0]     words_d;
  logic [31:0]         byte_word;
  logic                last_byte;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0]         csum_q, csum_d;
`endif

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= S_IDLE;
      lane_q       <= '0;
      shift_q      <= '0;
      len_q        <= '0;
      bram_addr    <= '0;
      bram_din     <= '0;
      bram_we      <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      words_loaded <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      lane_q       <= lane_d;
      shift_q      <= shift_d;
      len_q        <= len_d;
      bram_addr    <= addr_d;
      bram_din     <= din_d;
      bram_we      <= we_d;
      done         <= done_d;
      err          <= err_d;
      words_loaded <= words_d;
`ifdef LOADER_CHECKSUM_EN
      csum_q       <= csum_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    lane_d    = lane_q;
    shift_d   = shift_q;
    len_d     = len_q;
    addr_d    = bram_addr;
    din_d     = bram_din;
    we_d      = 1'b0;
    done_d    = done;
    err_d     = err;
    words_d   = words_loaded;
`ifdef LOADER_CHECKSUM_EN
    csum_d    = csum_q;
`endif
    // Little-endian: the newest byte lands in the top lane.
    byte_word = {rx_data, shift_q};
    last_byte = (lane_q == 2'd3);

    case (state_q)
      S_IDLE, S_DONE: begin
        // A byte arriving together with start is dropped.
        if (start) begin
          state_d = S_HDR;
          done_d  = 1'b0;
          err_d   = 1'b0;
          words_d = '0;
          lane_d  = '0;
`ifdef LOADER_CHECKSUM_EN
          csum_d  = '0;
`endif
        end
      end

      S_HDR: begin
        if (rx_valid) begin
          shift_d = byte_word[31:8];
          lane_d  = lane_q + 2'd1;
          if (last_byte) begin
            if ({1'b0, byte_word} > CAP) begin
              err_d   = 1'b1;
              done_d  = 1'b1;
              state_d = S_DONE;
            end else if (byte_word == '0) begin
`ifdef LOADER_CHECKSUM_EN
              state_d = S_CSUM;
`else
              done_d  = 1'b1;
              state_d = S_DONE;
`endif
            end else begin
              len_d   = byte_word[ADDR_W:0];
              state_d = S_DATA;
            end
          end
        end
      end

      S_DATA: begin
        // Without the trailer, DATA lingers one cycle after the final write
        // so that done follows the last bram_we pulse; bytes here are dropped.
        if (words_loaded == len_q) begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end else if (rx_valid) begin
          shift_d = byte_word[31:8];
          lane_d  = lane_q + 2'd1;
          if (last_byte) begin
            we_d    = 1'b1;
            addr_d  = words_loaded[ADDR_W-1:0];
            din_d   = byte_word;
            words_d = words_loaded + W_ONE;
`ifdef LOADER_CHECKSUM_EN
            csum_d  = csum_q + byte_word;
            if (words_loaded + W_ONE == len_q) state_d = S_CSUM;
`endif
          end
        end
      end

`ifdef LOADER_CHECKSUM_EN
      S_CSUM: begin
        if (rx_valid) begin
          shift_d = byte_word[31:8];
          lane_d  = lane_q + 2'd1;
          if (last_byte) begin
            err_d   = (byte_word != csum_q);
            done_d  = 1'b1;
            state_d = S_DONE;
          end
        end
      end
`endif

      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == S_HDR) || (state_q == S_DATA)
`ifdef LOADER_CHECKSUM_EN
           || (state_q == S_CSUM)
`endif
           ;
  end

endmodule

// File: tb/tb_inst_loader_ctrl.sv
// Self-checking bench for inst_loader_ctrl (ADDR_W=4). A byte-index model of
// the image format predicts every output each cycle; literal checks pin the
// directed scenarios from the write log.
module tb_inst_loader_ctrl;
  localparam int unsigned AW  = 4;
  localparam longint      CAP = 64'd1 << AW;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          start = 1'b0;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_data = '0;
  logic [AW-1:0] bram_addr;
  logic [31:0]   bram_din;
  logic          bram_we;
  logic          busy;
  logic          done;
  logic          err;
  logic [AW:0]   words_loaded;

  inst_loader_ctrl #(.ADDR_W(AW)) dut (
    .clk(clk), .rstn(rstn), .start(start), .rx_valid(rx_valid), .rx_data(rx_data),
    .bram_addr(bram_addr), .bram_din(bram_din), .bram_we(bram_we),
    .busy(busy), .done(done), .err(err), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: position in the byte stream decides everything.
  // byte n (1-based) <= 4: header; 4 < n <= 4+4N: payload; then trailer.
  bit          m_valid = 1'b0;
  bit          m_loading = 1'b0;
  bit          m_pend = 1'b0;
  longint      m_n = 0;
  logic [7:0]  m_bytes[$];
  logic [31:0] m_sum = '0;
  int          e_addr = 0, e_words = 0;
  logic [31:0] e_din = '0;
  bit          e_we = 0, e_busy = 0, e_done = 0, e_err = 0;

  function automatic logic [31:0] last_word();
    int n = m_bytes.size();
    return {m_bytes[n-1], m_bytes[n-2], m_bytes[n-3], m_bytes[n-4]};
  endfunction

  always @(posedge clk) begin
    if (!rstn) begin
      m_valid = 1; m_loading = 0; m_pend = 0;
      e_addr = 0; e_din = '0; e_we = 0; e_busy = 0; e_done = 0; e_err = 0; e_words = 0;
    end else if (m_valid) begin
      e_we = 0;
      if (m_pend) begin
        m_pend = 0; m_loading = 0; e_done = 1; e_busy = 0;
      end else if (!m_loading) begin
        if (start) begin
          m_loading = 1; e_busy = 1; e_done = 0; e_err = 0; e_words = 0;
          m_bytes.delete(); m_sum = '0;
        end
      end else if (rx_valid) begin
        int n;
        m_bytes.push_back(rx_data);
        n = m_bytes.size();
        if (n == 4) begin
          m_n = longint'(last_word());
          if (m_n > CAP) begin
            e_err = 1; e_done = 1; e_busy = 0; m_loading = 0;
          end else if (m_n == 0) begin
`ifndef LOADER_CHECKSUM_EN
            e_done = 1; e_busy = 0; m_loading = 0;
`endif
          end
        end else if (longint'(n) <= 4 + 4 * m_n) begin
          if (n % 4 == 0) begin
            e_we = 1; e_addr = e_words; e_din = last_word();
            e_words++; m_sum = m_sum + last_word();
`ifndef LOADER_CHECKSUM_EN
            if (longint'(n) == 4 + 4 * m_n) m_pend = 1;
`endif
          end
        end else if (longint'(n) == 8 + 4 * m_n) begin
          e_err = (last_word() != m_sum); e_done = 1; e_busy = 0; m_loading = 0;
        end
      end
    end
  end

  // Observed writes, used by the literal checks.
  int          log_addr[$];
  logic [31:0] log_din[$];

  always @(negedge clk) begin
    if (m_valid) begin
      cmp("bram_we", 32'(bram_we), 32'(e_we));
      cmp("bram_addr", 32'(bram_addr), 32'(e_addr));
      cmp("bram_din", bram_din, e_din);
      cmp("busy", 32'(busy), 32'(e_busy));
      cmp("done", 32'(done), 32'(e_done));
      cmp("err", 32'(err), 32'(e_err));
      cmp("words_loaded", 32'(words_loaded), 32'(e_words));
      if (bram_we === 1'b1) begin
        log_addr.push_back(int'(bram_addr));
        log_din.push_back(bram_din);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    rx_valid = 1'b1; rx_data = b; tick(); rx_valid = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    for (int i = 0; i < 4; i++) send(w[8*i +: 8], gap);
  endtask

  task automatic clear_log();
    log_addr.delete(); log_din.delete();
  endtask

  initial begin
    logic [31:0] w, s;
    rstn = 1'b0;
    repeat (3) tick();
    cmp("reset_we", 32'(bram_we), 0);
    cmp("reset_busy", 32'(busy), 0);
    cmp("reset_done", 32'(done), 0);
    cmp("reset_err", 32'(err), 0);
    cmp("reset_words", 32'(words_loaded), 0);
    rstn = 1'b1;
    tick();

    // Bytes in IDLE are ignored.
    clear_log();
    send(8'hAA, 0); send(8'h55, 1); send(8'h01, 0);
    cmp("idle_writes", 32'(log_addr.size()), 0);
    cmp("idle_busy", 32'(busy), 0);

    // Basic two-word load.
    clear_log();
    pulse_start();
    send_word(32'd2, 0);
    send_word(32'h12345678, 0);
    send_word(32'hDEADBEEF, 1);
`ifdef LOADER_CHECKSUM_EN
    send_word(32'hF0E21567, 0);
`endif
    repeat (3) tick();
    cmp("basic_nwr", 32'(log_addr.size()), 2);
    if (log_addr.size() == 2) begin
      cmp("basic_a0", 32'(log_addr[0]), 0);
      cmp("basic_d0", log_din[0], 32'h12345678);
      cmp("basic_a1", 32'(log_addr[1]), 1);
      cmp("basic_d1", log_din[1], 32'hDEADBEEF);
    end
    cmp("basic_words", 32'(words_loaded), 2);
    cmp("basic_done", 32'(done), 1);
    cmp("basic_err", 32'(err), 0);
    cmp("model_sum", m_sum, 32'hF0E21567);

`ifdef LOADER_CHECKSUM_EN
    pulse_start();
    send_word(32'd2, 0); send_word(32'h12345678, 0); send_word(32'hDEADBEEF, 0);
    send_word(32'h0, 0);
    repeat (2) tick();
    cmp("bad_csum_err", 32'(err), 1);
    cmp("bad_csum_done", 32'(done), 1);
`endif

    // Zero length, started from DONE.
    clear_log();
    pulse_start();
    cmp("restart_done_clr", 32'(done), 0);
    send_word(32'd0, 0);
`ifndef LOADER_CHECKSUM_EN
    cmp("zero_done_next", 32'(done), 1);
`else
    send_word(32'd0, 0);
`endif
    repeat (2) tick();
    cmp("zero_nwr", 32'(log_addr.size()), 0);
    cmp("zero_err", 32'(err), 0);

    // Oversize: 17 > 16 words.
    clear_log();
    pulse_start();
    send_word(32'd17, 0);
    cmp("over_err", 32'(err), 1);
    cmp("over_done", 32'(done), 1);
    repeat (2) tick();
    cmp("over_nwr", 32'(log_addr.size()), 0);

    // Full capacity, back-to-back.
    clear_log();
    pulse_start();
    send_word(32'd16, 0);
    s = '0;
    for (int i = 0; i < 16; i++) begin
      w = $urandom(); s = s + w; send_word(w, 0);
    end
`ifdef LOADER_CHECKSUM_EN
    send_word(s, 0);
`endif
    repeat (3) tick();
    cmp("full_nwr", 32'(log_addr.size()), 16);
    if (log_addr.size() == 16) cmp("full_last_addr", 32'(log_addr[15]), 15);
    cmp("full_words", 32'(words_loaded), 16);
    cmp("full_err", 32'(err), 0);

    // start while busy is ignored.
    pulse_start();
    send_word(32'd3, 0);
    pulse_start();
    for (int i = 0; i < 3; i++) send_word($urandom(), 0);
`ifdef LOADER_CHECKSUM_EN
    send_word(32'h0, 0);
`endif
    repeat (3) tick();
    cmp("busy_start_words", 32'(words_loaded), 3);

    // start and rx_valid together in DONE: the byte is dropped.
    start = 1'b1; rx_valid = 1'b1; rx_data = 8'h01; tick();
    start = 1'b0; rx_valid = 1'b0;
    send_word(32'd1, 0);
    send_word(32'hCAFEF00D, 0);
`ifdef LOADER_CHECKSUM_EN
    send_word(32'hCAFEF00D, 0);
`endif
    repeat (3) tick();
    cmp("drop_byte_words", 32'(words_loaded), 1);
    cmp("drop_byte_err", 32'(err), 0);

    // Reset after 5 payload bytes.
    pulse_start();
    send_word(32'd4, 0);
    for (int i = 0; i < 5; i++) send(8'(i + 1), 0);
    rstn = 1'b0; tick(); rstn = 1'b1;
    cmp("midrst_busy", 32'(busy), 0);
    cmp("midrst_words", 32'(words_loaded), 0);
    clear_log();
    for (int i = 0; i < 6; i++) send(8'(i), 0);
    tick();
    cmp("midrst_nwr", 32'(log_addr.size()), 0);

    // Randomized loads.
    for (int t = 0; t < 40; t++) begin
      int n, g;
      n = $urandom_range(0, 18);
      g = ($urandom_range(0, 3) == 0) ? 1 : 0;
      pulse_start();
      send_word(32'(n), g);
      if (n <= 16) begin
        s = '0;
        for (int i = 0; i < n; i++) begin
          w = $urandom(); s = s + w;
          if ($urandom_range(0, 7) == 0) start = 1'b1;
          send_word(w, $urandom_range(0, 1));
          start = 1'b0;
        end
`ifdef LOADER_CHECKSUM_EN
        if ($urandom_range(0, 3) == 0) s = s ^ 32'h1;
        send_word(s, g);
`endif
      end
      repeat ($urandom_range(2, 4)) tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/inst_loader_ctrl.md
# inst_loader_ctrl

Boot-time controller that sequences the instruction BRAM write port. It receives a program image as a byte stream from the UART receiver, assembles little-endian 32-bit words, and writes them to consecutive BRAM addresses starting at 0. It then raises a sticky `done` that releases the core from STALL mode into the BRAM-to-register-file copy and execution phases.

## Interface

Parameters:
- `ADDR_W`, default 14: instruction BRAM word-address width. Capacity is 2^ADDR_W words.

Ports:
- `clk`  in  1  single clock.
- `rstn`  in  1  reset, synchronous, active-low.
- `start`  in  1  one-cycle pulse that begins a load. Honoured only in IDLE or DONE.
- `rx_valid`  in  1  one-cycle strobe: `rx_data` holds a received byte.
- `rx_data`  in  8  received byte.
- `bram_addr`  out  ADDR_W  BRAM word address. Registered.
- `bram_din`  out  32  BRAM write data. Registered.
- `bram_we`  out  1  BRAM write enable. One-cycle pulse per word. Registered.
- `busy`  out  1  high while in HDR, DATA or CSUM.
- `done`  out  1  sticky load complete.
- `err`  out  1  sticky error: oversize length, or checksum mismatch when the checksum feature is compiled in.
- `words_loaded`  out  ADDR_W+1  count of words written in the current or last load.

## Operation

- **Reset values:** all outputs are 0. State is IDLE. The byte counter, word count and checksum accumulator are 0.
- **States:** IDLE, HDR, DATA, CSUM (present only with the macro), DONE.
- **IDLE / DONE + `start`:**
  - Clear `done`, `err`, `words_loaded`, the byte lane index and the checksum.
  - Go to HDR. `busy` rises the next cycle.
- **HDR:**
  - Collect 4 bytes, little-endian (first byte = bits 7:0), into a 32-bit length N in words.
  - On the 4th byte:
    - If N > 2^ADDR_W: set `err` and go to DONE.
    - Else if N = 0: go to CSUM if enabled, otherwise DONE.
    - Else: go to DATA.
- **DATA:**
  - Shift bytes into a word buffer, little-endian.
  - On the 4th byte of a word:
    - Register `bram_we`=1, `bram_addr`=`words_loaded`[ADDR_W-1:0], and `bram_din`=the assembled word.
    - Increment `words_loaded`.
    - Add the word to the checksum, mod 2^32.
  - After word N is written: go to CSUM if enabled, otherwise DONE.
- **CSUM:** collect 4 bytes little-endian. Compare against the accumulator; on mismatch set `err`. Go to DONE.
- **DONE:**
  - Set `done`=1; it holds until reset or the next `start`.
  - Ignore further `rx_valid`.
- **Ignored inputs:**
  - `rx_valid` in IDLE.
  - `start` while `busy`.
- **`start` and `rx_valid` in the same cycle in IDLE/DONE:** the start is taken and the byte is dropped.
- **Address range:** `bram_addr` never wraps. Because N is limited to 2^ADDR_W, the last address is 2^ADDR_W-1.
- **Reset mid-load:**
  - Abort immediately and return to IDLE with all outputs 0.
  - Words already written stay in the BRAM. No further write is issued.

## Timing

- Byte accepted at the edge where `rx_valid`=1. The back-to-back `rx_valid` maximum rate is 1 byte/cycle, and every byte is consumed.
- Write latency: the edge capturing the 4th byte of a word registers `bram_we`/`bram_addr`/`bram_din`. They are visible in the following cycle, for exactly 1 cycle.
- `words_loaded` updates on the same edge as `bram_we` is registered.
- `done`:
  - Without the macro: rises one cycle after the final `bram_we` pulse.
  - Zero-length or oversize loads: rises one cycle after the edge capturing the 4th header byte.
- `busy` falls in the same cycle that `done` rises.
- `err` rises together with `done`.

## Configuration

- `LOADER_CHECKSUM_EN` defined:
  - The CSUM state exists.
  - The image carries a 4-byte trailer equal to the mod-2^32 sum of all payload words.
  - On mismatch, `err`=1 with `done`=1. Words are still written.
  - `done` rises one cycle after the edge capturing the 4th trailer byte.
- Not defined:
  - No CSUM state and no accumulator.
  - `err` is set only by oversize length.
  - DATA goes directly to DONE.

## Test plan

- **Reset:** hold `rstn`=0 for 3 cycles → all outputs 0.
- **Basic load:** `start`, then bytes 02 00 00 00, 78 56 34 12, EF BE AD DE →
  - `bram_we` pulses at addr 0 with din 0x12345678.
  - `bram_we` pulses at addr 1 with din 0xDEADBEEF.
  - `words_loaded`=2, `done`=1, `err`=0.
  - With the macro, add trailer 67 15 E2 F0 (0xF0E21567) → `err`=0. A trailer of 00 00 00 00 → `err`=1.
- **Zero length:** header 00 00 00 00 → no `bram_we`, `done`=1 one cycle later (no macro).
- **Oversize:** ADDR_W=4, header 11 00 00 00 (17) → `err`=1, `done`=1, no write. Header 10 00 00 00 with 16 words → last write at addr 15, `err`=0.
- **Reset mid-load:** deassert `rstn` after 5 payload bytes → outputs 0, state IDLE. Subsequent `rx_valid` bytes produce no write until `start`.
- **Ignored inputs:**
  - Bytes sent in IDLE are ignored.
  - `start` while `busy` is ignored.
  - `start` in DONE clears `done` and begins a new load that rewrites from addr 0.
